// File: rtl/dump_pkg.sv
// dump_pkg: definitions shared by the memory dump reader and the byte-wise
// loader. It holds the FSM state encoding, the word geometry, the default
// sizes, and the little-endian byte-lane macro.
//   BYTE_LANE(k) selects lane k of a 32-bit word (bits 8k+7:8k).

`ifndef DUMP_BYTE_LANE
`define DUMP_BYTE_LANE(k) (8*(k)) +: 8
`endif

package dump_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int DEF_ADDR_W     = 12;
  localparam int DEF_REG_COUNT  = 16;
  localparam int DEF_REG_AW     = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REG,
    ST_MEM_ISSUE,
    ST_MEM_DRAIN,
    ST_OUT,
    ST_DONE
  } dump_state_e;

endpackage

// File: rtl/mem_dump_reader_byte_packer.sv
// byte_packer: builds one 32-bit word from byte lanes that arrive one at a time.
// Ports:
//   clk, reset         clock and asynchronous active-high reset
//   clr                zero the word (a new dump starts)
//   wr_en, lane        write byte_in into the given little-endian lane
//   byte_in            byte to store
//   word               assembled word

module byte_packer
  import dump_pkg::*;
(
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                clr,
  input  logic                                wr_en,
  input  logic [$clog2(BYTES_PER_WORD)-1:0]   lane,
  input  logic [7:0]                          byte_in,
  output logic [31:0]                         word
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word <= '0;
    end else if (clr) begin
      word <= '0;
    end else if (wr_en) begin
      word[`DUMP_BYTE_LANE(lane)] <= byte_in;
    end
  end

endmodule

// File: rtl/mem_dump_reader.sv
// mem_dump_reader: debug readback engine. When it sees start, it can first emit
// all register-file entries. It then reads word_count words of byte-addressed
// memory, packs the bytes little-endian, and streams them over valid/ready.
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   start, dump_regs                 request pulse and "registers first" flag
//   base_addr, word_count            first byte address (word aligned), word count
//   reg_rd_addr / reg_rd_data        combinational register-file read port
//   mem_rd_en/addr / mem_rd_data     byte memory read port, one-cycle latency
//   out_valid/ready/data/addr/is_reg output beat stream
//   busy, done                       request in flight, completion pulse
//
// State  | meaning
// IDLE   | waiting for start
// REG    | read register ri into the holding register
// ISSUE  | four byte reads at wa+0..3
// DRAIN  | capture the last byte in flight
// OUT    | present one beat until it is accepted
// DONE   | one-cycle done pulse

module mem_dump_reader
  import dump_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int REG_COUNT = DEF_REG_COUNT,
  parameter int REG_AW    = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              dump_regs,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-2:0] word_count,
  output logic [REG_AW-1:0] reg_rd_addr,
  input  logic [31:0]       reg_rd_data,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_is_reg,
  output logic              busy,
  output logic              done
);

  localparam int LANE_W = $clog2(BYTES_PER_WORD);

  dump_state_e       state, state_nxt;
  logic [REG_AW-1:0] ri;
  logic [LANE_W-1:0] k;
  logic [ADDR_W-1:0] wa;
  logic [ADDR_W-2:0] remaining;
  logic [31:0]       reg_q;
  logic              is_reg_q;
  logic              rd_pend;
  logic [LANE_W-1:0] rd_lane;
  logic [31:0]       pk_word;
  logic              accept;
  logic              last_reg;

  assign accept   = (state == ST_IDLE) && start;
  assign last_reg = (ri == REG_AW'(REG_COUNT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (dump_regs)            state_nxt = ST_REG;
          else if (word_count != 0) state_nxt = ST_MEM_ISSUE;
          else                      state_nxt = ST_DONE;
        end
      end
      ST_REG:       state_nxt = ST_OUT;
      ST_MEM_ISSUE: if (k == LANE_W'(BYTES_PER_WORD - 1)) state_nxt = ST_MEM_DRAIN;
      ST_MEM_DRAIN: state_nxt = ST_OUT;
      ST_OUT: begin
        if (out_ready) begin
          if (is_reg_q && !last_reg) state_nxt = ST_REG;
          else if (is_reg_q)         state_nxt = (remaining != 0) ? ST_MEM_ISSUE : ST_DONE;
          // Memory beat: 'remaining' still counts the word being accepted.
          else                       state_nxt = (remaining != 1) ? ST_MEM_ISSUE : ST_DONE;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ri        <= '0;
      k         <= '0;
      wa        <= '0;
      remaining <= '0;
      reg_q     <= '0;
      is_reg_q  <= 1'b0;
      rd_pend   <= 1'b0;
      rd_lane   <= '0;
    end else begin
      rd_pend <= mem_rd_en;
      rd_lane <= k;
      if (accept) begin
        wa        <= base_addr & ~ADDR_W'(BYTES_PER_WORD - 1);
        remaining <= word_count;
        ri        <= '0;
        k         <= '0;
        is_reg_q  <= 1'b0;
      end
      case (state)
        ST_REG: begin
          reg_q    <= reg_rd_data;
          is_reg_q <= 1'b1;
        end
        ST_MEM_ISSUE: begin
          k        <= k + 1'b1;
          is_reg_q <= 1'b0;
        end
        ST_OUT: begin
          if (out_ready) begin
            if (is_reg_q) begin
              ri <= last_reg ? '0 : ri + 1'b1;
            end else begin
              wa        <= wa + ADDR_W'(BYTES_PER_WORD);
              remaining <= remaining - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // The byte for lane k returns one cycle after its read, so the write lags issue.
  byte_packer u_packer (
    .clk     (clk),
    .reset   (reset),
    .clr     (accept),
    .wr_en   (rd_pend),
    .lane    (rd_lane),
    .byte_in (mem_rd_data),
    .word    (pk_word)
  );

  assign mem_rd_en   = (state == ST_MEM_ISSUE);
  assign mem_rd_addr = mem_rd_en ? (wa | ADDR_W'(k)) : '0;
  assign reg_rd_addr = (state == ST_REG) ? ri : '0;
  assign out_valid   = (state == ST_OUT);
  assign out_is_reg  = is_reg_q;
  assign out_data    = is_reg_q ? reg_q : pk_word;
  assign out_addr    = is_reg_q ? ADDR_W'(ri) : wa;
  assign busy        = (state != ST_IDLE) && (state != ST_DONE);
  assign done        = (state == ST_DONE);

endmodule
